// File: rtl/slot_releaser.sv
// Core-side slot tracker: validates TX-done/drop releases against the held bitmap and
// returns each freed slot exactly once, lowest ID first, one per cycle.
module slot_releaser #(
  parameter int unsigned SlotCount = 8,
  parameter int unsigned SlotWidth = $clog2(SlotCount + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 init_valid_i,
  input  logic [SlotWidth-1:0] alloc_slot_i,
  input  logic                 alloc_valid_i,
  input  logic [SlotWidth-1:0] rel_a_slot_i,
  input  logic                 rel_a_valid_i,
  output logic                 rel_a_ready_o,
  input  logic [SlotWidth-1:0] rel_b_slot_i,
  input  logic                 rel_b_valid_i,
  output logic                 rel_b_ready_o,
  output logic [SlotWidth-1:0] ret_slot_o,
  output logic                 ret_valid_o,
  output logic [SlotWidth-1:0] held_count_o,
  output logic                 rel_err_o,
  output logic                 alloc_err_o,
  output logic [SlotWidth-1:0] err_slot_o
);

  typedef enum logic [0:0] {StWaitInit, StRun} state_e;

  state_e               state_q, state_d;
  logic [SlotCount:1]   held_q, held_d, pend_q, pend_d;
  logic [SlotWidth-1:0] cnt_q, cnt_d, ret_slot_q, ret_slot_d, err_slot_q, err_slot_d;
  logic                 ret_valid_q, ret_valid_d, rel_err_q, rel_err_d, alloc_err_q, alloc_err_d;

  // One-hot decode of a slot ID; 0 and out-of-range IDs decode to all zeros.
  function automatic logic [SlotCount:1] decode(input logic [SlotWidth-1:0] s);
    logic [SlotCount:1] oh;
    for (int unsigned i = 1; i <= SlotCount; i++) oh[i] = (s == SlotWidth'(i));
    return oh;
  endfunction

  logic [SlotCount:1] a_oh, b_oh, al_oh;
  assign a_oh  = decode(rel_a_slot_i);
  assign b_oh  = decode(rel_b_slot_i);
  assign al_oh = decode(alloc_slot_i);

  logic run, a_hs, b_hs, a_ok, b_ok, a_inv, b_inv, al_hit, al_dup;
  logic [SlotCount:1]   sel_oh;
  logic [SlotWidth-1:0] sel_idx;
  int                   cnt_next;

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    ret_slot_d  = ret_slot_q;
    ret_valid_d = 1'b0;
    rel_err_d   = rel_err_q;
    alloc_err_d = alloc_err_q;
    err_slot_d  = err_slot_q;
    sel_oh      = '0;
    sel_idx     = '0;
    cnt_next    = 0;

    run    = (state_q == StRun);
    a_hs   = run & rel_a_valid_i;
    b_hs   = run & rel_b_valid_i;
    // All validity checks see the bitmaps as they stood at the start of the cycle.
    a_ok   = a_hs & |(a_oh & held_q);
    b_ok   = b_hs & |(b_oh & held_q) & ~(a_ok & (a_oh == b_oh));
    a_inv  = a_hs & ~a_ok;
    b_inv  = b_hs & ~b_ok;
    al_hit = run & alloc_valid_i & |al_oh;
    al_dup = al_hit & |(al_oh & (held_q | pend_q));

    for (int unsigned i = SlotCount; i >= 1; i--) begin
      if (pend_q[i]) begin
        sel_oh  = '0;
        sel_oh[i] = 1'b1;
        sel_idx = SlotWidth'(i);
      end
    end

    if (init_valid_i) begin
      state_d     = StRun;
      held_d      = '0;
      pend_d      = '0;
      cnt_d       = '0;
      rel_err_d   = 1'b0;
      alloc_err_d = 1'b0;
      err_slot_d  = '0;
    end else if (run) begin
      if (|pend_q) begin
        ret_valid_d = 1'b1;
        ret_slot_d  = sel_idx;
      end
      // Clear the returned slot before marking new releases pending.
      pend_d = (pend_q & ~sel_oh) | (a_ok ? a_oh : '0) | (b_ok ? b_oh : '0);
      held_d = (held_q & ~(a_ok ? a_oh : '0) & ~(b_ok ? b_oh : '0)) | (al_hit ? al_oh : '0);

      cnt_next = int'(cnt_q) + int'(al_hit & ~al_dup) - int'(a_ok) - int'(b_ok);
      if (cnt_next < 0)                   cnt_d = '0;
      else if (cnt_next > int'(SlotCount)) cnt_d = SlotWidth'(SlotCount);
      else                                 cnt_d = SlotWidth'(cnt_next);

      if (al_dup) alloc_err_d = 1'b1;
      if (a_inv | b_inv) begin
        rel_err_d = 1'b1;
        if (!rel_err_q) err_slot_d = a_inv ? rel_a_slot_i : rel_b_slot_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StWaitInit;
      held_q      <= '0;
      pend_q      <= '0;
      cnt_q       <= '0;
      ret_slot_q  <= '0;
      ret_valid_q <= 1'b0;
      rel_err_q   <= 1'b0;
      alloc_err_q <= 1'b0;
      err_slot_q  <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      ret_slot_q  <= ret_slot_d;
      ret_valid_q <= ret_valid_d;
      rel_err_q   <= rel_err_d;
      alloc_err_q <= alloc_err_d;
      err_slot_q  <= err_slot_d;
    end
  end

  assign rel_a_ready_o = (state_q == StRun);
  assign rel_b_ready_o = (state_q == StRun);
  assign ret_slot_o    = ret_slot_q;
  assign ret_valid_o   = ret_valid_q;
  assign held_count_o  = cnt_q;
  assign rel_err_o     = rel_err_q;
  assign alloc_err_o   = alloc_err_q;
  assign err_slot_o    = err_slot_q;

endmodule

// File: doc/slot_releaser.md
# slot_releaser

Core-side counterpart of the scheduler's free-slot pool. It tracks which packet slots a core currently holds, accepts slot releases from two independent sources (TX-done and drop), validates them, and returns each freed slot exactly once to the slot pool's single-entry, no-backpressure return port, at most one per cycle. It sits between the core's packet-completion logic and the slot pool's `slot_in`/`slot_in_valid` inputs.

## Interface

- `SLOT_COUNT`, default 8, number of slots; valid slot IDs are 1..SLOT_COUNT, and 0 is never a slot.
- `SLOT_WIDTH`, default `$clog2(SLOT_COUNT+1)`, width of a slot ID.

- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `init_valid` input 1: pool (re)initialisation; clears all tracking state.
- `alloc_slot` input SLOT_WIDTH: slot granted to the core (pool `slot_out`).
- `alloc_valid` input 1: grant strobe (pool `slot_out_valid && slot_out_pop`).
- `rel_a_slot` input SLOT_WIDTH: TX-done release slot.
- `rel_a_valid` input 1: TX-done release valid.
- `rel_a_ready` output 1: TX-done release ready.
- `rel_b_slot` input SLOT_WIDTH: drop release slot.
- `rel_b_valid` input 1: drop release valid.
- `rel_b_ready` output 1: drop release ready.
- `ret_slot` output SLOT_WIDTH: slot returned to the pool.
- `ret_valid` output 1: return strobe, one slot per cycle, no backpressure.
- `held_count` output SLOT_WIDTH: number of slots currently held.
- `rel_err` output 1: sticky; an invalid release was discarded.
- `alloc_err` output 1: sticky; a slot was granted while already held or pending.
- `err_slot` output SLOT_WIDTH: slot ID of the first invalid release since init.

## Operation

- **State machine.** There are two states.
  - WAIT_INIT is entered on `rst`. In this state both readies are 0 and `alloc_valid` is ignored.
  - RUN is entered on `init_valid` from either state. In this state both readies are 1.
- **Init.** `init_valid` in RUN re-clears all state: `held`, `pending`, `held_count`, the error flags, `err_slot`, and `ret_valid`.
- **Bitmaps.** `held[SLOT_COUNT:1]` marks slots owned by the core. `pending[SLOT_COUNT:1]` marks slots that have been released but not yet returned. The pending bitmap is the only buffer. It cannot overflow because slot IDs are unique.
- **Alloc.**
  - `alloc_valid` sets `held[alloc_slot]`.
  - If `held` or `pending` was already 1 for that slot, `alloc_err` is set; the held bit still ends at 1.
  - `alloc_slot` equal to 0 is ignored.
- **Release validity.** A release handshake (valid && ready) is valid only if:
  - the slot is in 1..SLOT_COUNT, and
  - `held[slot]` was 1 at the start of the cycle.
- **Valid release.** Clears `held[slot]` and sets `pending[slot]`.
- **Invalid release.** Discarded. Sets `rel_err`; `err_slot` captures the slot if `rel_err` was 0.
- **Same slot on both channels in one cycle.**
  - A is accepted; B counts as invalid (double release).
  - Both handshakes complete, so B is not stalled.
- **Checks use pre-cycle state.** An alloc and a release of the same slot in one cycle are evaluated against the bitmaps before that cycle's update.
  - If the slot was held: the release is valid and `alloc_err` is set. End state is held=1, pending=1.
  - If the slot was not held: the release is invalid and the alloc proceeds normally.
- **Return.**
  - Each RUN cycle the lowest-index set bit of `pending` is selected, cleared, and registered onto `ret_slot`, with `ret_valid`=1.
  - If no pending bit is set, `ret_valid`=0 and `ret_slot` holds its last value.
- **`held_count`.** Increments by 1 per alloc with a nonzero slot that did not raise `alloc_err`, and decrements per valid release (0, 1 or 2 per cycle). The net change is applied in one update and saturates at 0 and SLOT_COUNT.

## Timing

- **Reset values.** `rel_a_ready`=0, `rel_b_ready`=0, `ret_valid`=0, `ret_slot`=0, `held_count`=0, `rel_err`=0, `alloc_err`=0, `err_slot`=0. The state is WAIT_INIT.
- **Readies.** Registered from the state, so they rise in the cycle after `init_valid`.
- **Release-to-return latency.** A release accepted in cycle N sets pending at the end of N. `ret_valid` is high in cycle N+2 when no lower-index slot is pending; otherwise it is delayed 1 cycle per lower pending slot.
- **Two valid releases in one cycle.** They return on consecutive cycles, lower ID first.
- **Errors and count.** `rel_err`, `alloc_err`, `err_slot` and `held_count` are registered and update 1 cycle after the causing event.
- **Reset mid-operation.** Pending slots are dropped without being returned. `rst` has priority over `init_valid`, and `init_valid` has priority over all other events in the same cycle.

## Test plan

- **Basic return.** Steps: `rst`, then `init_valid`, then alloc slots 3, 1, 5, then release A=1. Required: `held_count` goes 1, 2, 3, 2; `ret_valid`=1 with `ret_slot`=1 two cycles after the release; no errors.
- **Dual release.** Steps: hold slots 2 and 6, then release A=6 and B=2 in the same cycle. Required: returns 2 then 6 on consecutive cycles; `held_count` drops by 2 in one update.
- **Double release, same cycle.** Steps: hold slot 4, then release A=4 and B=4 together. Required: a single return of 4, `rel_err`=1, `err_slot`=4, `held_count` decremented by 1.
- **Invalid releases.** Steps: release slot 0, then slot SLOT_COUNT+1, then an unheld slot 7. Required: no returns, `rel_err`=1, `err_slot`=0 (first error), `held_count` unchanged.
- **Double alloc.** Steps: alloc slot 2 twice. Required: `alloc_err`=1 and `held_count`=1. After `init_valid`: all flags 0, `held_count`=0, and releasing 2 is now invalid.
- **Reset gating and reset mid-operation.** Steps: assert release valids before `init_valid`. Required: readies stay 0 and nothing is returned. Then: with slots 1-8 pending, assert `rst`. Required: `ret_valid`=0 the next cycle, and no further returns.
